// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP layer sequencer.
package mlp_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIN
    } seq_state_t;

    // A one-layer build still needs a one-bit select bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// Sequencer-to-datapath link: start/done handshake, activation vector and weight select.
interface mlp_sequencer_if
    import mlp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LAYERS = 3,
    parameter int DW     = mlp_pkg::DW
);
    localparam int IW = idx_width(LAYERS);

    logic                layer_start;
    logic [WIDTH*DW-1:0] layer_x;
    logic [IW-1:0]       layer_idx;
    logic                layer_done;
    logic [WIDTH*DW-1:0] layer_y;

    modport master (
        output layer_start, layer_x, layer_idx,
        input  layer_done, layer_y
    );

    modport slave (
        input  layer_start, layer_x, layer_idx,
        output layer_done, layer_y
    );

endinterface

// File: rtl/mlp_sequencer_watchdog.sv
// Cycle counter that flags when a layer has been waited on for TIMEOUT cycles.
module mlp_sequencer_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired;

    assign expired   = (cnt_q == CW'(TIMEOUT - 1));
    assign expired_o = expired;

    // Saturates at the terminal count so a stalled enable can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mlp_sequencer.sv
// Runs one square layer datapath LAYERS times per inference, feeding each output back as the next input.
//   state | meaning
//   IDLE  | waiting for start; outputs held
//   ISSUE | layer_start pulse for the current layer; watchdog cleared
//   WAIT  | waiting for layer_done or watchdog expiry
//   FIN   | done pulse; y_out already loaded
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LAYERS  = 3,
    parameter int DW      = mlp_pkg::DW,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [WIDTH*DW-1:0] x_in_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [WIDTH*DW-1:0] y_out_o,
    mlp_sequencer_if.master     dp
);
    localparam int            IW   = idx_width(LAYERS);
    localparam logic [IW-1:0] LAST = IW'(LAYERS - 1);

    seq_state_t          state_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                lstart_q;
    logic [WIDTH*DW-1:0] y_q;
    logic [WIDTH*DW-1:0] act_q;
    logic [IW-1:0]       idx_q;

    logic wdog_clear;
    logic wdog_en;
    logic wdog_expired;

    assign wdog_clear = (state_q == ISSUE);
    assign wdog_en    = (state_q == WAIT) && !dp.layer_done;

    mlp_sequencer_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wdog_clear),
        .enable_i  (wdog_en),
        .expired_o (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            lstart_q <= 1'b0;
            y_q      <= '0;
            act_q    <= '0;
            idx_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            lstart_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        act_q    <= x_in_i;
                        idx_q    <= '0;
                        error_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        lstart_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done arriving in the expiry cycle still counts as success.
                    if (dp.layer_done) begin
                        act_q <= dp.layer_y;
                        if (idx_q == LAST) begin
                            y_q     <= dp.layer_y;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            lstart_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end else if (wdog_expired) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign y_out_o        = y_q;
    assign dp.layer_start = lstart_q;
    assign dp.layer_x     = act_q;
    assign dp.layer_idx   = idx_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench: behavioural stand-in datapath, directed vector table, corner sequences and random inferences.
module tb_mlp_sequencer;
    import mlp_pkg::*;

    localparam int W  = 4;
    localparam int L  = 3;
    localparam int D  = 16;
    localparam int TO = 20;
    localparam int VW = W * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // ---------------- instance A: three layers ----------------
    logic          start_a = 1'b0;
    logic [VW-1:0] x_a     = '0;
    logic          busy_a, done_a, err_a;
    logic [VW-1:0] y_a;
    logic          dp_done_a = 1'b0;
    logic [VW-1:0] dp_y_a    = '0;
    logic          force_a   = 1'b0;
    logic [VW-1:0] junk_a    = {4{16'h5A5A}};

    mlp_sequencer_if #(.WIDTH(W), .LAYERS(L), .DW(D)) la ();
    assign la.layer_done = dp_done_a | force_a;
    assign la.layer_y    = force_a ? junk_a : dp_y_a;

    mlp_sequencer #(.WIDTH(W), .LAYERS(L), .DW(D), .TIMEOUT(TO)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_a),
        .x_in_i  (x_a),
        .busy_o  (busy_a),
        .done_o  (done_a),
        .error_o (err_a),
        .y_out_o (y_a),
        .dp      (la)
    );

    // ---------------- instance B: single layer ----------------
    logic          start_b = 1'b0;
    logic [VW-1:0] x_b     = '0;
    logic          busy_b, done_b, err_b;
    logic [VW-1:0] y_b;
    logic          dpb_done = 1'b0;
    logic [VW-1:0] dpb_y    = '0;

    mlp_sequencer_if #(.WIDTH(W), .LAYERS(1), .DW(D)) lb ();
    assign lb.layer_done = dpb_done;
    assign lb.layer_y    = dpb_y;

    mlp_sequencer #(.WIDTH(W), .LAYERS(1), .DW(D), .TIMEOUT(TO)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_b),
        .x_in_i  (x_b),
        .busy_o  (busy_b),
        .done_o  (done_b),
        .error_o (err_b),
        .y_out_o (y_b),
        .dp      (lb)
    );

    // ---------------- layer function: y = ReLU(W*x >> FRAC + b), saturated ----------------
    logic signed [D-1:0] w_tab [L][W][W];
    logic signed [D-1:0] b_tab [L][W];

    function automatic logic [VW-1:0] layer_fn(input int li, input logic [VW-1:0] xv);
        logic [VW-1:0] yv;
        longint        acc;
        yv = '0;
        for (int i = 0; i < W; i++) begin
            acc = 0;
            for (int j = 0; j < W; j++)
                acc += longint'(w_tab[li][i][j]) * longint'($signed(xv[j*D +: D]));
            acc = (acc >>> FRAC) + longint'(b_tab[li][i]);
            if (acc < 0) acc = 0;
            else if (acc > 32767) acc = 32767;
            yv[i*D +: D] = acc[D-1:0];
        end
        return yv;
    endfunction

    function automatic logic [VW-1:0] mlp_ref(input logic [VW-1:0] xv);
        logic [VW-1:0] v;
        v = xv;
        for (int li = 0; li < L; li++) v = layer_fn(li, v);
        return v;
    endfunction

    task automatic set_identity();
        for (int li = 0; li < L; li++)
            for (int i = 0; i < W; i++) begin
                b_tab[li][i] = '0;
                for (int j = 0; j < W; j++) w_tab[li][i][j] = (i == j) ? 16'sh0100 : 16'sh0000;
            end
    endtask

    // ---------------- datapath stand-ins: layer_done comes dp_lat cycles after the start cycle ----------------
    int            dp_lat   = W + 1;
    int            hold_idx = -1;
    int            dp_cnt   = 0;
    int            dp_idx   = 0;
    bit            dp_hold  = 1'b0;
    logic [VW-1:0] dp_x     = '0;

    always @(negedge clk) begin
        dp_done_a = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0 && !dp_hold) begin
                dp_done_a = 1'b1;
                dp_y_a    = layer_fn(dp_idx, dp_x);
            end
        end
        if (la.layer_start) begin
            dp_cnt  = dp_lat;
            dp_idx  = int'(la.layer_idx);
            dp_x    = la.layer_x;
            dp_hold = (dp_idx == hold_idx);
        end
    end

    int            dpb_cnt = 0;
    logic [VW-1:0] dpb_x   = '0;

    always @(negedge clk) begin
        dpb_done = 1'b0;
        if (dpb_cnt > 0) begin
            dpb_cnt--;
            if (dpb_cnt == 0) begin
                dpb_done = 1'b1;
                dpb_y    = layer_fn(0, dpb_x);
            end
        end
        if (lb.layer_start) begin
            dpb_cnt = W + 1;
            dpb_x   = lb.layer_x;
        end
    end

    // ---------------- observers ----------------
    int            ls_cnt = 0, ls_first = 0, ls_last = 0;
    int            done_cnt = 0, done_cyc = 0, err_cyc = -1;
    bit            err_prev = 1'b0;
    logic [VW-1:0] y_done = '0;
    int            idx_log[$];

    always @(negedge clk) begin
        if (la.layer_start) begin
            if (ls_cnt == 0) ls_first = cyc;
            ls_last = cyc;
            idx_log.push_back(int'(la.layer_idx));
            ls_cnt++;
        end
        if (done_a) begin
            done_cnt++;
            done_cyc = cyc;
            y_done   = y_a;
        end
        if (err_a && !err_prev) err_cyc = cyc;
        err_prev = err_a;
    end

    int            lsb_cnt = 0, lsb_first = 0, doneb_cnt = 0, doneb_cyc = 0, b_bad_idx = 0;
    logic [VW-1:0] yb_done = '0;

    always @(negedge clk) begin
        if (lb.layer_start) begin
            lsb_cnt++;
            lsb_first = cyc;
            if (lb.layer_idx != 1'b0) b_bad_idx++;
        end
        if (done_b) begin
            doneb_cnt++;
            doneb_cyc = cyc;
            yb_done   = y_b;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        ls_cnt   = 0;
        done_cnt = 0;
        err_cyc  = -1;
        idx_log.delete();
    endtask

    // Called just after a rising edge; start is seen at the next edge.
    task automatic launch_a(input logic [VW-1:0] x, input bit spam);
        clear_obs();
        start_a = 1'b1;
        x_a     = x;
        @(posedge clk);
        #1;
        x_a = {$urandom, $urandom};
        if (!spam) start_a = 1'b0;
    endtask

    task automatic wait_end_a(input string tag);
        bit ended;
        ended = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            if (done_cnt > 0 || err_cyc >= 0) begin
                ended = 1'b1;
                break;
            end
        end
        #1 start_a = 1'b0;
        chk({tag, "_ended"}, 64'(ended), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [VW-1:0] exp_y, input bit exp_err,
                           input int exp_ls, input int exp_span);
        chk({tag, "_ndone"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        chk({tag, "_err"}, 64'(err_a), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_nls"}, 64'(ls_cnt), 64'(exp_ls));
        foreach (idx_log[i]) chk($sformatf("%s_idx%0d", tag, i), 64'(idx_log[i]), 64'(i));
        if (exp_err) begin
            chk({tag, "_tspan"}, 64'(err_cyc - ls_last), 64'(exp_span));
        end else begin
            chk({tag, "_dspan"}, 64'(done_cyc - ls_first), 64'(exp_span));
            chk({tag, "_ydone"}, y_done, exp_y);
            chk({tag, "_yheld"}, y_a, exp_y);
        end
    endtask

    typedef struct {
        logic [VW-1:0] x;
        int            lat;
        int            hold;
        bit            spam;
        logic [VW-1:0] exp_y;
        bit            exp_err;
        int            exp_ls;
        int            exp_span;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [VW-1:0] xr, ey;
        int            lat;

        set_identity();
        // Element 0 is the least significant slice.
        tbl[0] = '{{16'h0040, 16'hFF80, 16'h0200, 16'h0100}, W + 1, -1, 1'b0,
                   {16'h0040, 16'h0000, 16'h0200, 16'h0100}, 1'b0, 3, L * (W + 2)};
        tbl[1] = '{{16'h0040, 16'hFF80, 16'h0200, 16'h0100}, W + 1, -1, 1'b1,
                   {16'h0040, 16'h0000, 16'h0200, 16'h0100}, 1'b0, 3, L * (W + 2)};
        tbl[2] = '{{16'h0001, 16'h7FFF, 16'h0080, 16'hFE00}, W + 1, 1, 1'b0,
                   '0, 1'b1, 2, TO + 1};
        tbl[3] = '{{16'h0001, 16'h7FFF, 16'h0080, 16'hFE00}, W + 1, -1, 1'b0,
                   {16'h0001, 16'h7FFF, 16'h0080, 16'h0000}, 1'b0, 3, L * (W + 2)};
        tbl[4] = '{{4{16'h0100}}, TO, -1, 1'b0,
                   {4{16'h0100}}, 1'b0, 3, L * (TO + 1)};
        tbl[5] = '{{4{16'h0100}}, TO + 1, -1, 1'b0,
                   '0, 1'b1, 1, TO + 1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_y", y_a, 64'd0);
        chk("rst_lstart", 64'(la.layer_start), 64'd0);
        chk("rst_lx", la.layer_x, 64'd0);
        chk("rst_lidx", 64'(la.layer_idx), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        chk("rst_b_y", y_b, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-layer build.
        start_b = 1'b1;
        x_b     = {4{16'h0100}};
        @(posedge clk);
        #1;
        start_b = 1'b0;
        x_b     = '1;
        for (int k = 0; k < 100 && doneb_cnt == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("b_ndone", 64'(doneb_cnt), 64'd1);
        chk("b_nls", 64'(lsb_cnt), 64'd1);
        chk("b_badidx", 64'(b_bad_idx), 64'd0);
        chk("b_dspan", 64'(doneb_cyc - lsb_first), 64'(1 * (W + 2)));
        chk("b_ydone", yb_done, {4{16'h0100}});
        chk("b_busy", 64'(busy_b), 64'd0);

        // Directed table.
        foreach (tbl[i]) begin
            dp_lat   = tbl[i].lat;
            hold_idx = tbl[i].hold;
            launch_a(tbl[i].x, tbl[i].spam);
            wait_end_a($sformatf("v%0d", i));
            check_a($sformatf("v%0d", i), tbl[i].exp_y, tbl[i].exp_err, tbl[i].exp_ls, tbl[i].exp_span);
            repeat (TO + 4) @(posedge clk);
            #1;
        end
        dp_lat   = W + 1;
        hold_idx = -1;

        // Spurious layer_done while idle: nothing moves, last good result held.
        clear_obs();
        force_a = 1'b1;
        @(posedge clk);
        #1 force_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_spur_busy", 64'(busy_a), 64'd0);
        chk("idle_spur_nls", 64'(ls_cnt), 64'd0);
        chk("idle_spur_y", y_a, tbl[4].exp_y);
        chk("idle_spur_lidx", 64'(la.layer_idx), 64'd0);

        // Spurious layer_done during ISSUE: ignored, sequence and result unchanged.
        clear_obs();
        start_a = 1'b1;
        x_a     = tbl[0].x;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        force_a = 1'b1;
        @(posedge clk);
        #1 force_a = 1'b0;
        wait_end_a("issue_spur");
        check_a("issue_spur", tbl[0].exp_y, 1'b0, 3, L * (W + 2));

        // Random weights, inputs and datapath latency against the composed reference.
        for (int r = 0; r < 12; r++) begin
            for (int li = 0; li < L; li++)
                for (int i = 0; i < W; i++) begin
                    b_tab[li][i] = 16'(int'($urandom_range(128, 0)) - 64);
                    for (int j = 0; j < W; j++)
                        w_tab[li][i][j] = 16'(int'($urandom_range(512, 0)) - 256);
                end
            for (int i = 0; i < W; i++) xr[i*D +: D] = 16'(int'($urandom_range(1024, 0)) - 512);
            lat    = int'($urandom_range(TO - 1, 1));
            dp_lat = lat;
            ey     = mlp_ref(xr);
            launch_a(xr, r[0]);
            wait_end_a($sformatf("r%0d", r));
            check_a($sformatf("r%0d", r), ey, 1'b0, 3, L * (lat + 1));
        end
        set_identity();
        dp_lat = W + 1;

        // Reset in WAIT of the last layer; the stale layer_done lands two cycles after reset.
        launch_a(tbl[0].x, 1'b0);
        for (int k = 0; k < 100 && ls_cnt < 3; k++) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_nls", 64'(ls_cnt), 64'd3);
        chk("mrst_ndone", 64'(done_cnt), 64'd0);
        chk("mrst_busy", 64'(busy_a), 64'd0);
        chk("mrst_done", 64'(done_a), 64'd0);
        chk("mrst_err", 64'(err_a), 64'd0);
        chk("mrst_y", y_a, 64'd0);
        chk("mrst_lstart", 64'(la.layer_start), 64'd0);
        chk("mrst_lx", la.layer_x, 64'd0);
        chk("mrst_lidx", 64'(la.layer_idx), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 ns");
        $fatal(1);
    end

endmodule
